// File: rtl/binary16_div_pkg.sv
// binary16_div_pkg: shared types, divider latency and pointer helper for the binary16 divider arbiter.
package binary16_div_pkg;
  typedef logic [15:0] binary16_t;
  localparam int DIV_LATENCY = 25;
  localparam int DEFAULT_N_REQ = 4;
  typedef logic [$clog2(DEFAULT_N_REQ)-1:0] req_tag_t;
  function automatic int wrap_inc(input int p, input int depth);
    return (p + 1 == depth) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/binary16_div_arbiter_rr.sv
// rr_arbiter: one-hot round-robin grant; the search starts just after i_last_grant.
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last_grant,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx
);
  logic [IW-1:0] w_idx;
  logic          w_found;
  always_comb begin
    o_grant = '0;
    o_grant_idx = '0;
    w_found = 1'b0;
    w_idx = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(i_last_grant) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx = w_idx;
      end
    end
  end
endmodule

// File: rtl/binary16_div_arbiter.sv
// binary16_div_arbiter: round-robin front end sharing one pipelined binary16 divider, routing results back via an in-order tag FIFO.
// Optional saturating perf counters (perf_issued, perf_stall) when BINARY16_DIV_ARB_PERF_EN is defined.
module binary16_div_arbiter
  import binary16_div_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TAG_DEPTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  binary16_t [N_REQ-1:0] req_a,
  input  binary16_t [N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output binary16_t             div_a,
  output binary16_t             div_b,
  output logic                  div_valid_in,
  input  binary16_t             div_result,
  input  logic                  div_valid_out,
  output logic [N_REQ-1:0]      resp_valid,
  output binary16_t             resp_result,
  output logic                  err_orphan
`ifdef BINARY16_DIV_ARB_PERF_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_stall
`endif
);
  localparam int TW = $clog2(N_REQ);
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);

  logic [TW-1:0]    r_last;
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_count;
  logic [TW-1:0]    r_tags [TAG_DEPTH];
  logic [N_REQ-1:0] w_arb_req, w_grant;
  logic [TW-1:0]    w_gidx, w_head;
  logic             w_can_issue, w_push, w_pop, w_orphan;

  // A full FIFO may still accept when a result pops in the same cycle.
  assign w_can_issue = (r_count < CW'(TAG_DEPTH)) || (div_valid_out && r_count == CW'(TAG_DEPTH));
  assign w_arb_req = (w_can_issue && !rst) ? req_valid : '0;
  assign req_ready = w_grant;
  assign w_push = |w_grant;
  assign w_pop = div_valid_out && (r_count != '0);
  assign w_orphan = div_valid_out && (r_count == '0);
  assign w_head = r_tags[r_rp];

  rr_arbiter #(.N(N_REQ), .IW(TW)) u_rr (
    .i_req(w_arb_req),
    .i_last_grant(r_last),
    .o_grant(w_grant),
    .o_grant_idx(w_gidx)
  );

  always_ff @(posedge clk_in)
    if (w_push) r_tags[r_wp] <= w_gidx;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_last <= TW'(N_REQ - 1);
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      div_valid_in <= 1'b0;
      div_a <= '0;
      div_b <= '0;
      resp_valid <= '0;
      resp_result <= '0;
      err_orphan <= 1'b0;
    end else begin
      div_valid_in <= w_push;
      if (w_push) begin
        div_a <= req_a[w_gidx];
        div_b <= req_b[w_gidx];
        r_last <= w_gidx;
        r_wp <= PW'(wrap_inc(int'(r_wp), TAG_DEPTH));
      end
      if (w_pop) begin
        r_rp <= PW'(wrap_inc(int'(r_rp), TAG_DEPTH));
        resp_result <= div_result;
      end
      resp_valid <= w_pop ? (N_REQ'(1) << w_head) : '0;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      err_orphan <= err_orphan | w_orphan;
    end
  end

`ifdef BINARY16_DIV_ARB_PERF_EN
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall <= '0;
    end else begin
      if (w_push && !(&perf_issued)) perf_issued <= perf_issued + 32'd1;
      if (|req_valid && !w_push && !(&perf_stall)) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  // no performance counters in this build
`endif
endmodule

// File: tb/tb_binary16_div_arbiter.sv
// tb_binary16_div_arbiter: scoreboard bench with a 25-cycle divider model (default DUT) and a 10-cycle model (TAG_DEPTH=4 DUT).
module tb_binary16_div_arbiter;
  import binary16_div_pkg::*;
  localparam int N = 4;
  localparam int SLAT = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [N-1:0] req_valid, req_ready, resp_valid;
  binary16_t [N-1:0] req_a, req_b;
  binary16_t div_a, div_b, div_result, resp_result;
  logic div_valid_in, div_valid_out, err_orphan;

  logic [N-1:0] s_valid, s_ready, s_resp_valid;
  binary16_t [N-1:0] s_req_a, s_req_b;
  binary16_t s_div_a, s_div_b, s_div_result, s_resp_result;
  logic s_dvi, s_dvo, s_err;
  assign s_req_a = {N{16'h3C00}};
  assign s_req_b = {N{16'h4000}};

`ifdef BINARY16_DIV_ARB_PERF_EN
  logic [31:0] perf_issued, perf_stall, s_perf_issued, s_perf_stall;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int        tag;
    binary16_t res;
    int        due;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int m_last = N - 1;
  int m_idx;
  logic [N-1:0] m_exp;

  // Known quotients for the spec operands; other pairs get an asymmetric stand-in so routing errors show.
  function automatic binary16_t div_fn(input binary16_t a, input binary16_t b);
    if (a == 16'h3C00 && b == 16'h4000) return 16'h3800;
    if (a == 16'h4600 && b == 16'h4200) return 16'h4000;
    return a + (b << 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [DIV_LATENCY-1:0] p_v = '0;
  binary16_t p_a [DIV_LATENCY];
  binary16_t p_b [DIV_LATENCY];
  always @(posedge clk) begin
    p_v <= {p_v[DIV_LATENCY-2:0], div_valid_in};
    p_a[0] <= div_a;
    p_b[0] <= div_b;
    for (int i = 1; i < DIV_LATENCY; i++) begin
      p_a[i] <= p_a[i-1];
      p_b[i] <= p_b[i-1];
    end
  end
  assign div_valid_out = p_v[DIV_LATENCY-1];
  assign div_result = p_v[DIV_LATENCY-1] ? div_fn(p_a[DIV_LATENCY-1], p_b[DIV_LATENCY-1]) : 16'h0000;

  logic [SLAT-1:0] q_v = '0;
  binary16_t q_a [SLAT];
  binary16_t q_b [SLAT];
  always @(posedge clk) begin
    q_v <= {q_v[SLAT-2:0], s_dvi};
    q_a[0] <= s_div_a;
    q_b[0] <= s_div_b;
    for (int i = 1; i < SLAT; i++) begin
      q_a[i] <= q_a[i-1];
      q_b[i] <= q_b[i-1];
    end
  end
  assign s_dvo = q_v[SLAT-1];
  assign s_div_result = s_dvo ? div_fn(q_a[SLAT-1], q_b[SLAT-1]) : 16'h0000;

  binary16_div_arbiter #(.N_REQ(N), .TAG_DEPTH(32)) u_dut (
    .clk_in(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .div_a(div_a), .div_b(div_b), .div_valid_in(div_valid_in),
    .div_result(div_result), .div_valid_out(div_valid_out), .resp_valid(resp_valid),
    .resp_result(resp_result), .err_orphan(err_orphan)
`ifdef BINARY16_DIV_ARB_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  binary16_div_arbiter #(.N_REQ(N), .TAG_DEPTH(4)) u_small (
    .clk_in(clk), .rst(rst), .req_valid(s_valid), .req_a(s_req_a), .req_b(s_req_b),
    .req_ready(s_ready), .div_a(s_div_a), .div_b(s_div_b), .div_valid_in(s_dvi),
    .div_result(s_div_result), .div_valid_out(s_dvo), .resp_valid(s_resp_valid),
    .resp_result(s_resp_result), .err_orphan(s_err)
`ifdef BINARY16_DIV_ARB_PERF_EN
    , .perf_issued(s_perf_issued), .perf_stall(s_perf_stall)
`endif
  );

  // Default DUT never fills its 32-entry FIFO here, so the grant is pure round-robin.
  always @(negedge clk) begin
    if (rst) begin
      m_last = N - 1;
      sb.delete();
    end else begin
      m_exp = '0;
      for (int k = 1; k <= N; k++) begin
        m_idx = (m_last + k) % N;
        if (m_exp == '0 && req_valid[m_idx]) m_exp[m_idx] = 1'b1;
      end
      chk("grant", 32'(req_ready), 32'(m_exp));
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) begin
          m_last = i;
          sb.push_back('{i, div_fn(req_a[i], req_b[i]), cyc + 1 + DIV_LATENCY + 1});
        end
      if (resp_valid != '0) begin
        if (sb.size() == 0) chk("resp_unexpected", 32'(resp_valid), 32'd0);
        else begin
          e = sb.pop_front();
          chk("resp_tag", 32'(resp_valid), 32'd1 << e.tag);
          chk("resp_result", 32'(resp_result), 32'(e.res));
          chk("resp_latency", cyc, e.due);
        end
      end
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    int n, t0, n_resp;
    logic exp_ready;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    s_valid = '0;
    repeat (2) @(posedge clk);
    #1 req_valid = '1;
    s_valid = '1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_div_valid_in", 32'(div_valid_in), 32'd0);
    chk("rst_div_a", 32'(div_a), 32'd0);
    chk("rst_div_b", 32'(div_b), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_result", 32'(resp_result), 32'd0);
    chk("rst_err_orphan", 32'(err_orphan), 32'd0);
    req_valid = '0;
    s_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;

    // All four requesters continuously valid: grants 0,1,2,3,0,...
    req_a = {N{16'h4600}};
    req_b = {N{16'h4200}};
    req_valid = '1;
    for (int g = 0; g < 12; g++) begin
      @(negedge clk);
      chk("rr_grant_seq", 32'(req_ready), 32'd1 << (g % N));
    end
    @(posedge clk);
    #1 req_valid = '0;
    drain("rr_drain");

    // Single request from requester 0.
    @(posedge clk);
    #1 req_valid = 4'b0001;
    req_a[0] = 16'h3C00;
    req_b[0] = 16'h4000;
    t0 = cyc;
    @(posedge clk);
    #1 req_valid = '0;
    chk("issue_valid", 32'(div_valid_in), 32'd1);
    chk("issue_a", 32'(div_a), 32'h3C00);
    chk("issue_b", 32'(div_b), 32'h4000);
    @(posedge clk);
    #1;
    chk("issue_drop", 32'(div_valid_in), 32'd0);
    chk("issue_hold_a", 32'(div_a), 32'h3C00);
    chk("issue_hold_b", 32'(div_b), 32'h4000);
    n = 0;
    while (!resp_valid[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("single_timeout", 32'(n < 40), 32'd1);
    chk("single_latency", cyc - t0, 27);
    chk("single_result", 32'(resp_result), 32'h3800);
    drain("single_drain");

    // Distinct operands per requester with sparse valid patterns.
    for (int i = 0; i < N; i++) begin
      req_a[i] = 16'h4000 + 16'(i << 8);
      req_b[i] = 16'h3C00 + 16'(i);
    end
    @(posedge clk);
    #1 req_valid = 4'b1010;
    repeat (6) @(posedge clk);
    #1 req_valid = 4'b0111;
    repeat (5) @(posedge clk);
    #1 req_valid = 4'b0100;
    repeat (2) @(posedge clk);
    #1 req_valid = '0;
    drain("mixed_drain");

    // Reset with 10 tags outstanding; returning results must be treated as orphans.
    req_valid = '1;
    repeat (10) @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_div_valid_in", 32'(div_valid_in), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("orphan_pre_err", 32'(err_orphan), 32'd0);
    n_resp = 0;
    repeat (30) begin
      @(negedge clk);
      if (resp_valid != '0) n_resp++;
    end
    chk("orphan_resp_count", n_resp, 0);
    chk("orphan_err", 32'(err_orphan), 32'd1);
    chk("orphan_count", 32'(u_dut.r_count), 32'd0);

    // Normal service resumes after the orphans; err_orphan stays sticky.
    req_a[2] = 16'h4600;
    req_b[2] = 16'h4200;
    @(posedge clk);
    #1 req_valid = 4'b0100;
    @(posedge clk);
    #1 req_valid = '0;
    drain("post_orphan_drain");
    chk("orphan_sticky", 32'(err_orphan), 32'd1);

    // TAG_DEPTH=4 with a 10-cycle divider: 4 issues, stall, then issue on each pop.
    @(posedge clk);
    #1 s_valid = '1;
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      exp_ready = (r < 4) || (r >= 11 && r < 15);
      chk("small_ready", 32'(|s_ready), 32'(exp_ready));
      if (r < 4) chk("small_grant", 32'(s_ready), 32'd1 << r);
      if (r == 11) chk("small_reissue_grant", 32'(s_ready), 32'd1);
      if (r == 12) begin
        chk("small_resp_valid", 32'(s_resp_valid), 32'd1);
        chk("small_resp_result", 32'(s_resp_result), 32'h3800);
      end
    end
    @(posedge clk);
    #1 s_valid = '0;
    repeat (30) @(posedge clk);
    #1;
    chk("small_err", 32'(s_err), 32'd0);
`ifdef BINARY16_DIV_ARB_PERF_EN
    chk("perf_issued", s_perf_issued, 32'd8);
    chk("perf_stall", s_perf_stall, 32'd8);
`endif
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/binary16_div_arbiter.md
BINARY16_DIV_ARBITER -- requirements
Module: binary16_div_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requester ports (2..8).
REQ-002 Parameter TAG_DEPTH, default 32, tag FIFO entries; must be >= divider latency (25) so the full pipeline can be occupied.
REQ-003 clk_in  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  N_REQ  per-requester operation request.
REQ-006 req_a, req_b  input  N_REQ x 16  binary16 dividend and divisor per requester.
REQ-007 req_ready  output  N_REQ  one-hot accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 div_a, div_b  output  16  registered operands to the divider.
REQ-009 div_valid_in  output  1  registered issue strobe to the divider.
REQ-010 div_result  input  16, div_valid_out  input  1  divider return path.
REQ-011 resp_valid  output  N_REQ  one-hot, one-cycle result strobe per requester.
REQ-012 resp_result  output  16  shared result bus, valid only while any resp_valid bit is high.
REQ-013 err_orphan  output  1  sticky flag: a result arrived with no outstanding tag.

Function
REQ-014 The block shall accept at most one request per cycle, granted round-robin: search starts at (last_grant+1) mod N_REQ; last_grant updates only on an actual transfer.
REQ-015 req_ready shall be combinational from req_valid, last_grant and FIFO state; req_ready[i] shall never assert without req_valid[i].
REQ-016 Issue is allowed when tag count < TAG_DEPTH, or when count == TAG_DEPTH and div_valid_out is high in the same cycle (simultaneous pop frees a slot).
REQ-017 On a transfer from requester i, the next edge shall set div_valid_in=1, div_a=req_a[i], div_b=req_b[i] and push tag i; with no transfer, div_valid_in=0 and div_a/div_b hold their values.
REQ-018 Issue latency shall be exactly 1 cycle from transfer to div_valid_in; back-to-back issue every cycle shall be sustained.
REQ-019 The tag FIFO shall be in order: on div_valid_out the head tag is popped and, on the next edge, resp_valid[tag]=1 and resp_result=div_result; total latency from transfer to resp_valid is 1 + divider latency + 1 cycles.
REQ-020 Simultaneous push and pop shall leave the count unchanged; read/write pointers wrap modulo TAG_DEPTH.
REQ-021 div_valid_out with the FIFO empty shall produce no resp_valid, shall not change the count, and shall set err_orphan until reset.
REQ-022 Responses have no backpressure; requesters must accept resp_valid in the cycle it is asserted.

Reset
REQ-023 On rst, asynchronously: req_ready=0 (combinational from cleared state), div_valid_in=0, div_a=div_b=0, resp_valid=0, resp_result=0, err_orphan=0, last_grant=N_REQ-1 (requester 0 has first priority), FIFO pointers and count = 0.
REQ-024 Reset mid-operation discards all outstanding tags; results returning afterward from a not-yet-flushed divider are handled per REQ-021.

Configuration
REQ-025 Macro BINARY16_DIV_ARB_PERF_EN: when defined, add outputs perf_issued (32-bit, counts transfers) and perf_stall (32-bit, counts cycles with any req_valid high and no transfer), both saturating at all-ones and cleared by rst; when undefined, these ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-026 Package binary16_div_pkg shall hold typedef binary16_t (16-bit), constant DIV_LATENCY=25, and typedef req_tag_t sized $clog2(N_REQ) for the default N_REQ.
REQ-027 Round-robin selection shall be a separate sub-module rr_arbiter (inputs req, last_grant; outputs one-hot grant, grant index).

Verification
REQ-028 Single request: req 0 sends a=0x3C00, b=0x4000 -> div_valid_in one cycle later; resp_valid[0] with resp_result=0x3800 after 1+25+1 cycles.
REQ-029 All four requesters valid continuously with a=0x4600, b=0x4200 -> grants 0,1,2,3,0,... one per cycle; each resp_valid[i] returns 0x4000 in grant order.
REQ-030 TAG_DEPTH=4 with a stub divider of latency 10, constant requests -> exactly 4 issues, then req_ready low until the first div_valid_out, then issue in that same cycle.
REQ-031 Assert rst with 10 tags outstanding; divider model keeps returning results -> no resp_valid, err_orphan=1, count stays 0.
REQ-032 With BINARY16_DIV_ARB_PERF_EN, 8 transfers and 3 stalled cycles -> perf_issued=8, perf_stall=3; without the macro, elaboration succeeds with no perf ports.
